// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit for the ARMv4 subset (ADD/SUB/AND/ORR, LDR/STR, B).
// Owns the main FSM, the NZCV register, the condition check and the memory handshake.
module arm_multicycle_ctrl #(
  parameter int unsigned RESET_STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [19:0]              instr,
  input  logic [3:0]               alu_flags,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     pc_write,
  output logic                     adr_src,
  output logic                     ir_write,
  output logic                     mem_write,
  output logic                     reg_write,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               result_src,
  output logic [1:0]               alu_control,
  output logic [1:0]               imm_src,
  output logic [1:0]               reg_src,
  output logic [3:0]               flags,
  output logic                     illegal,
  output logic [RESET_STATE_W-1:0] dbg_state
);

  // Encoding follows the state list order; it is exported on dbg_state.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExR    = 4'd6,
    StExI    = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e     state_q;
  logic       cond_q;
  logic [3:0] flags_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic [1:0] dp_op;
  logic       dp_arith;
  logic       unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign rd_is_pc  = (rd == 4'hF);
  assign unused_rn = ^instr[7:4];

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = !z;
      4'b0010: cond_check = cy;
      4'b0011: cond_check = !cy;
      4'b0100: cond_check = n;
      4'b0101: cond_check = !n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = !v;
      4'b1000: cond_check = cy && !z;
      4'b1001: cond_check = !cy || z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = !z && (n == v);
      4'b1101: cond_check = z || (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  always_comb begin
    dp_op = 2'b00;
    case (funct[4:1])
      4'b0100: dp_op = 2'b00;
      4'b0010: dp_op = 2'b01;
      4'b0000: dp_op = 2'b10;
      4'b1100: dp_op = 2'b11;
      default: dp_op = 2'b00;
    endcase
  end

  // C and V only change for arithmetic operations.
  assign dp_arith = (dp_op == 2'b00) || (dp_op == 2'b01);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      case (state_q)
        StFetch: if (mem_ready) state_q <= StDecode;
        StDecode: begin
          cond_q <= cond_check(cond, flags_q);
          case (op)
            2'b00:   state_q <= funct[5] ? StExI : StExR;
            2'b01:   state_q <= StMemAdr;
            2'b10:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= funct[0] ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state_q <= StMemWb;
        StMemWb:  state_q <= StFetch;
        StMemWr:  if (!cond_q || mem_ready) state_q <= StFetch;
        StExR, StExI: begin
          if (funct[0] && cond_q) begin
            flags_q[3:2] <= alu_flags[3:2];
            if (dp_arith) flags_q[1:0] <= alu_flags[1:0];
          end
          state_q <= StAluWb;
        end
        StAluWb:  state_q <= StFetch;
        StBranch: state_q <= StFetch;
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Gating on reset drops any pending request without waiting for a clock edge.
  always_comb begin
    mem_req     = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    illegal     = 1'b0;
    if (reset) begin
      case (state_q)
        StFetch: begin
          mem_req    = 1'b1;
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        StDecode: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          illegal    = (op == 2'b11);
        end
        StMemAdr: alu_src_b = 2'b01;
        StMemRd: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        StMemWb: begin
          result_src = 2'b01;
          reg_write  = cond_q;
          pc_write   = cond_q && rd_is_pc;
        end
        StMemWr: begin
          mem_req   = cond_q;
          adr_src   = 1'b1;
          mem_write = cond_q;
        end
        StExR: alu_control = dp_op;
        StExI: begin
          alu_src_b   = 2'b01;
          alu_control = dp_op;
        end
        StAluWb: begin
          reg_write = cond_q;
          pc_write  = cond_q && rd_is_pc;
        end
        StBranch: begin
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = cond_q;
        end
        default: ;
      endcase
    end
  end

  assign imm_src   = op;
  assign reg_src   = {(op == 2'b01) && !funct[0], op == 2'b10};
  assign flags     = flags_q;
  assign dbg_state = RESET_STATE_W'(state_q);

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed instruction sequences plus random instructions,
// checked against a per-instruction state-path and write-count model.
module tb_arm_multicycle_ctrl;

  localparam int SFetch  = 0;
  localparam int SDecode = 1;
  localparam int SMemAdr = 2;
  localparam int SMemRd  = 3;
  localparam int SMemWb  = 4;
  localparam int SMemWr  = 5;
  localparam int SExR    = 6;
  localparam int SExI    = 7;
  localparam int SAluWb  = 8;
  localparam int SBranch = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] instr = '0;
  logic [3:0]  alu_flags = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, result_src, alu_control, imm_src, reg_src;
  logic [3:0]  flags, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] mflags = 4'b0000;

  arm_multicycle_ctrl #(.RESET_STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .imm_src(imm_src), .reg_src(reg_src), .flags(flags), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM condition semantics: cond[3:1] picks a predicate, cond[0] inverts it.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, p;
    {n, z, cy, v} = f;
    p = 1'b0;
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cy;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cy & ~z;
      3'd5: p = (n == v);
      3'd6: p = ~z & (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? ~p : p;
  endfunction

  function automatic logic [1:0] alu_op_of(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  // fw/mw: wait cycles with mem_ready low during fetch / data access.
  task automatic run_instr(input logic [19:0] ins, input int fw, input int mw,
                           input logic [3:0] af);
    int   path[$];
    bit   rdy[$];
    logic [1:0] op, aop;
    logic [5:0] fn;
    logic pass, dp, ld, st, br;
    int   exp_pc, exp_rw, exp_mw, exp_mreq, exp_ill;
    int   c_pc, c_rw, c_mw, c_mreq, c_ill, c_ir;
    op   = ins[15:14];
    fn   = ins[13:8];
    aop  = alu_op_of(fn[4:1]);
    pass = cond_pass(ins[19:16], mflags);
    dp = (op == 2'b00); ld = (op == 2'b01) && fn[0];
    st = (op == 2'b01) && !fn[0]; br = (op == 2'b10);
    for (int i = 0; i <= fw; i++) begin path.push_back(SFetch); rdy.push_back(i == fw); end
    path.push_back(SDecode); rdy.push_back(1'($urandom));
    if (dp) begin
      path.push_back(fn[5] ? SExI : SExR); rdy.push_back(1'($urandom));
      path.push_back(SAluWb); rdy.push_back(1'($urandom));
    end else if (ld) begin
      path.push_back(SMemAdr); rdy.push_back(1'($urandom));
      for (int i = 0; i <= mw; i++) begin path.push_back(SMemRd); rdy.push_back(i == mw); end
      path.push_back(SMemWb); rdy.push_back(1'($urandom));
    end else if (st) begin
      path.push_back(SMemAdr); rdy.push_back(1'($urandom));
      if (pass) begin
        for (int i = 0; i <= mw; i++) begin path.push_back(SMemWr); rdy.push_back(i == mw); end
      end else begin
        path.push_back(SMemWr); rdy.push_back(1'($urandom));
      end
    end else if (br) begin
      path.push_back(SBranch); rdy.push_back(1'($urandom));
    end
    exp_pc   = 1 + ((pass && (((dp || ld) && ins[3:0] == 4'hF) || br)) ? 1 : 0);
    exp_rw   = (pass && (dp || ld)) ? 1 : 0;
    exp_mw   = (st && pass) ? mw + 1 : 0;
    exp_mreq = fw + 1 + (ld ? mw + 1 : 0) + ((st && pass) ? mw + 1 : 0);
    exp_ill  = (op == 2'b11) ? 1 : 0;
    c_pc = 0; c_rw = 0; c_mw = 0; c_mreq = 0; c_ill = 0; c_ir = 0;
    for (int k = 0; k < path.size(); k++) begin
      @(posedge clk);
      #1;
      mem_ready = rdy[k];
      alu_flags = af;
      if (path[k] != SFetch) instr = ins;
      @(negedge clk);
      check_eq("state", dbg_state, path[k]);
      c_pc += int'(pc_write); c_rw += int'(reg_write); c_mw += int'(mem_write);
      c_mreq += int'(mem_req); c_ill += int'(illegal); c_ir += int'(ir_write);
      if (path[k] == SFetch && rdy[k]) begin
        check_eq("fetch_srca", alu_src_a, 1'b1);
        check_eq("fetch_srcb", alu_src_b, 2'b10);
        check_eq("fetch_res", result_src, 2'b10);
      end
      if (path[k] == SDecode) begin
        check_eq("imm_src", imm_src, op);
        check_eq("reg_src", reg_src, {st, br});
      end
      if (path[k] == SExR || path[k] == SExI) begin
        check_eq("alu_ctl", alu_control, aop);
        check_eq("ex_srcb", alu_src_b, (path[k] == SExI) ? 2'b01 : 2'b00);
      end
      if (path[k] == SMemRd) check_eq("rd_adr", adr_src, 1'b1);
      if (path[k] == SMemWb) check_eq("wb_res", result_src, 2'b01);
      if (path[k] == SBranch) check_eq("br_srcb", alu_src_b, 2'b01);
    end
    if (dp && fn[0] && pass) begin
      mflags[3:2] = af[3:2];
      if (aop == 2'b00 || aop == 2'b01) mflags[1:0] = af[1:0];
    end
    check_eq("flags", flags, mflags);
    check_eq("ir_write_cnt", c_ir, 1);
    check_eq("pc_write_cnt", c_pc, exp_pc);
    check_eq("reg_write_cnt", c_rw, exp_rw);
    check_eq("mem_write_cnt", c_mw, exp_mw);
    check_eq("mem_req_cnt", c_mreq, exp_mreq);
    check_eq("illegal_cnt", c_ill, exp_ill);
  endtask

  initial begin
    logic [19:0] adds5, subs5, beq, strne, ill, adds_f, ldr, ri;
    logic [3:0]  cmd;
    logic        s_bit;
    logic [1:0]  rop;
    adds5  = {4'hE, 2'b00, 6'b101001, 4'h0, 4'h1};
    subs5  = {4'hE, 2'b00, 6'b100101, 4'h1, 4'h2};
    beq    = {4'h0, 2'b10, 6'b100000, 4'h0, 4'h0};
    strne  = {4'h1, 2'b01, 6'b011000, 4'h0, 4'h2};
    ill    = {4'hE, 2'b11, 6'b000000, 4'h0, 4'h0};
    adds_f = {4'hE, 2'b00, 6'b101001, 4'h0, 4'h3};
    ldr    = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h4};

    // Reset held with memory ready: no writes, no request.
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, SFetch);
    check_eq("rst_flags", flags, 4'b0000);
    check_eq("rst_ir_write", ir_write, 1'b0);
    check_eq("rst_pc_write", pc_write, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_illegal", illegal, 1'b0);
    mem_ready = 1'b0;
    reset = 1'b1;

    run_instr(adds5, 0, 0, 4'b0000);
    run_instr(subs5, 0, 0, 4'b0110);
    check_eq("subs_flags", flags, 4'b0110);
    run_instr(ldr, 0, 3, 4'b0000);
    run_instr(beq, 0, 0, 4'b0000);
    run_instr(adds5, 1, 0, 4'b0000);
    run_instr(beq, 0, 0, 4'b0000);
    run_instr(subs5, 0, 0, 4'b0100);
    run_instr(strne, 0, 2, 4'b0000);
    run_instr(ill, 0, 0, 4'b0000);
    run_instr(strne, 2, 2, 4'b0000);

    // Reset in the middle of a waiting load.
    run_instr(adds_f, 0, 0, 4'hF);
    @(posedge clk); #1 mem_ready = 1'b1;
    @(posedge clk); #1 begin mem_ready = 1'b0; instr = ldr; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst_pre_state", dbg_state, SMemRd);
    check_eq("midrst_pre_req", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_req", mem_req, 1'b0);
    check_eq("midrst_state", dbg_state, SFetch);
    check_eq("midrst_flags", flags, 4'b0000);
    mflags = 4'b0000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_ir_write", ir_write, 1'b0);
    mem_ready = 1'b0;
    reset = 1'b1;
    run_instr(ldr, 1, 1, 4'b0000);

    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom);
      s_bit = 1'($urandom);
      case ($urandom_range(0, 4))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        default: begin cmd = 4'($urandom); s_bit = 1'b0; end
      endcase
      ri[19:16] = 4'($urandom);
      ri[15:14] = rop;
      ri[13:8]  = (rop == 2'b00) ? {1'($urandom), cmd, s_bit} : 6'($urandom);
      ri[7:4]   = 4'($urandom);
      ri[3:0]   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(ri, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
